// File: rtl/lane_pause_update_ctrl.sv
// Pauses the HS IO clock around each lane delay-code update (four-phase REQ/ACK).
// Define LANE_PAUSE_STATS_EN to add the saturating UPD_COUNT completed-update counter.
module lane_pause_update_ctrl #(
  parameter int unsigned        DELAY_W     = 8,
  parameter logic [DELAY_W-1:0] INIT_CODE   = '0,
  parameter int unsigned        PRE_CYCLES  = 2,
  parameter int unsigned        POST_CYCLES = 2,
  parameter int unsigned        GAP_CYCLES  = 1
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               UPD_REQ,
  input  logic [DELAY_W-1:0] UPD_CODE,
  output logic               UPD_ACK,
  output logic               BUSY,
  output logic               HS_IO_CLK_PAUSE,
  output logic               DLY_LOAD,
  output logic [DELAY_W-1:0] DLY_CODE
`ifdef LANE_PAUSE_STATS_EN
  ,
  output logic [15:0]        UPD_COUNT
`endif
);

  generate
    if (DELAY_W < 1) begin : g_bad_width
      $error("DELAY_W must be at least 1");
    end
    if (PRE_CYCLES < 1 || PRE_CYCLES > 255) begin : g_bad_pre
      $error("PRE_CYCLES must be in 1..255");
    end
    if (POST_CYCLES > 255) begin : g_bad_post
      $error("POST_CYCLES must be in 0..255");
    end
    if (GAP_CYCLES > 255) begin : g_bad_gap
      $error("GAP_CYCLES must be in 0..255");
    end
  endgenerate

  // Counter reload values; unused ones wrap harmlessly when a window is zero-length.
  localparam logic [7:0] PRE_LOAD  = 8'(PRE_CYCLES - 1);
  localparam logic [7:0] POST_LOAD = 8'(POST_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_LOAD,
    S_POST,
    S_ACK,
    S_GAP
  } state_t;

  state_t             state;
  logic [7:0]         cnt;
  logic [DELAY_W-1:0] code_q;

  // Outputs are registered alongside the state so each one reflects the state being entered.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state           <= S_IDLE;
      cnt             <= 8'd0;
      code_q          <= INIT_CODE;
      UPD_ACK         <= 1'b0;
      BUSY            <= 1'b0;
      HS_IO_CLK_PAUSE <= 1'b0;
      DLY_LOAD        <= 1'b0;
      DLY_CODE        <= INIT_CODE;
    end else begin
      DLY_LOAD <= 1'b0;
      case (state)
        S_IDLE: begin
          if (UPD_REQ) begin
            code_q          <= UPD_CODE;
            cnt             <= PRE_LOAD;
            state           <= S_PRE;
            HS_IO_CLK_PAUSE <= 1'b1;
            BUSY            <= 1'b1;
          end
        end
        S_PRE: begin
          if (cnt == 8'd0) begin
            state    <= S_LOAD;
            DLY_LOAD <= 1'b1;
            DLY_CODE <= code_q;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_LOAD: begin
          if (POST_CYCLES > 0) begin
            state <= S_POST;
            cnt   <= POST_LOAD;
          end else begin
            state           <= S_ACK;
            HS_IO_CLK_PAUSE <= 1'b0;
            UPD_ACK         <= 1'b1;
          end
        end
        S_POST: begin
          if (cnt == 8'd0) begin
            state           <= S_ACK;
            HS_IO_CLK_PAUSE <= 1'b0;
            UPD_ACK         <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_ACK: begin
          // An early-dropped request still walks through one ACK cycle here.
          if (!UPD_REQ) begin
            UPD_ACK <= 1'b0;
            if (GAP_CYCLES > 0) begin
              state <= S_GAP;
              cnt   <= GAP_LOAD;
            end else begin
              state <= S_IDLE;
              BUSY  <= 1'b0;
            end
          end
        end
        S_GAP: begin
          if (cnt == 8'd0) begin
            state <= S_IDLE;
            BUSY  <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: begin
          state           <= S_IDLE;
          UPD_ACK         <= 1'b0;
          BUSY            <= 1'b0;
          HS_IO_CLK_PAUSE <= 1'b0;
        end
      endcase
    end
  end

`ifdef LANE_PAUSE_STATS_EN
  // Counts a load once its LOAD cycle completes, so a reset during LOAD is not counted.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      UPD_COUNT <= 16'd0;
    end else if (state == S_LOAD && UPD_COUNT != 16'hFFFF) begin
      UPD_COUNT <= UPD_COUNT + 16'd1;
    end
  end
`else
  // Statistics counter not built.
`endif

endmodule

// File: tb/tb_lane_pause_update_ctrl.sv
// Scoreboard bench for lane_pause_update_ctrl: three parameter sets, random handshakes,
// expectations from a timeline model of each update's pause/load/ack windows.
module tb_lane_pause_update_ctrl;

  typedef struct packed {
    logic        pause;
    logic        load;
    logic        ack;
    logic        busy;
    logic [7:0]  code;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int PRE  = (g == 2) ? 1 : 2;
    localparam int POST = (g == 0) ? 2 : ((g == 1) ? 0 : 3);
    localparam int GAP  = (g == 0) ? 1 : ((g == 1) ? 0 : 2);
    localparam logic [7:0] INIT = (g == 2) ? 8'h5A : 8'h00;
    localparam int W = PRE + 1 + POST;

    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic [7:0] code = 8'h00;
    logic       ack, busy, pause, load;
    logic [7:0] dly_code;
`ifdef LANE_PAUSE_STATS_EN
    logic [15:0] upd_count;
`endif
    bit scramble = 1'b0;
    bit done = 1'b0;

    exp_t       exp_q[$];
    logic [7:0] load_q[$];

    lane_pause_update_ctrl #(
      .DELAY_W    (8),
      .INIT_CODE  (INIT),
      .PRE_CYCLES (PRE),
      .POST_CYCLES(POST),
      .GAP_CYCLES (GAP)
    ) dut (
      .CLK            (clk),
      .RESET          (rst),
      .UPD_REQ        (req),
      .UPD_CODE       (code),
      .UPD_ACK        (ack),
      .BUSY           (busy),
      .HS_IO_CLK_PAUSE(pause),
      .DLY_LOAD       (load),
      .DLY_CODE       (dly_code)
`ifdef LANE_PAUSE_STATS_EN
      ,
      .UPD_COUNT      (upd_count)
`endif
    );

    function automatic string nm(input string s);
      return $sformatf("cfg%0d %s", g, s);
    endfunction

    function automatic exp_t reset_vec();
      exp_t v;
      v = '0;
      v.code = INIT;
      return v;
    endfunction

    // Reference model: an accepted update at edge a owns cycles a+1.. ; pause for W cycles,
    // load at offset PRE+1, ack from W+1 until req is seen low, then GAP busy cycles.
    initial begin
      int   e = 0;
      int   o;
      bit   m_active = 1'b0;
      int   m_acc = 0;
      int   m_next_ok = 0;
      int   m_cnt = 0;
      bit   m_last_load = 1'b0;
      logic [7:0] m_cap = 8'h00;
      logic [7:0] m_code = INIT;
      exp_t v;
      forever begin
        @(posedge clk);
        if (rst) begin
          m_active = 1'b0; m_next_ok = 0; m_cnt = 0; m_last_load = 1'b0; m_code = INIT;
          v = reset_vec();
        end else begin
          if (m_last_load && m_cnt < 65535) m_cnt++;
          if (!m_active) begin
            if (e >= m_next_ok && req) begin
              m_active = 1'b1; m_acc = e; m_cap = code;
            end
          end else if (e - m_acc >= W + 1 && !req) begin
            m_active = 1'b0; m_next_ok = e + GAP + 1;
          end
          o = e + 1 - m_acc;
          v.pause = m_active && o >= 1 && o <= W;
          v.load  = m_active && o == PRE + 1;
          v.ack   = m_active && o >= W + 1;
          v.busy  = m_active || (e + 1 < m_next_ok);
          if (v.load) begin
            m_code = m_cap;
            load_q.push_back(m_cap);
          end
          v.code = m_code;
          v.cnt = m_cnt[15:0];
          m_last_load = v.load;
        end
        exp_q.push_back(v);
        e++;
      end
    end

    // Monitor: compare every cycle away from the active edge.
    initial begin
      exp_t x;
      forever begin
        @(negedge clk);
        if (exp_q.size() > 0) begin
          x = exp_q.pop_front();
          check_output(nm("pause"), 32'(pause), 32'(x.pause));
          check_output(nm("dly_load"), 32'(load), 32'(x.load));
          check_output(nm("upd_ack"), 32'(ack), 32'(x.ack));
          check_output(nm("busy"), 32'(busy), 32'(x.busy));
          check_output(nm("dly_code"), 32'(dly_code), 32'(x.code));
`ifdef LANE_PAUSE_STATS_EN
          check_output(nm("upd_count"), 32'(upd_count), 32'(x.cnt));
`endif
        end
        if (load) begin
          if (load_q.size() > 0) check_output(nm("load_code"), 32'(dly_code), 32'(load_q.pop_front()));
          else check_output(nm("unexpected_load"), 32'(load), 32'd0);
        end
      end
    end

    task automatic step();
      @(posedge clk);
      #1;
      if (scramble) code = 8'($urandom);
    endtask

    task automatic wait_ack();
      int n = 0;
      while (!ack && n < 100) begin step(); n++; end
      check_output(nm("ack_seen"), 32'(ack), 32'd1);
    endtask

    task automatic wait_load();
      int n = 0;
      while (!load && n < 100) begin step(); n++; end
      check_output(nm("load_seen"), 32'(load), 32'd1);
    endtask

    // Asynchronous reset mid-cycle; the pending expectation for this cycle becomes the reset state.
    task automatic do_reset(input int n);
      rst = 1'b1;
      exp_q.delete();
      load_q.delete();
      exp_q.push_back(reset_vec());
      repeat (n) step();
      rst = 1'b0;
    endtask

    task automatic apply_stimulus();
      int pick;
      code = 8'h35; req = 1'b1;
      step();
      code = 8'h7F;
      wait_ack();
      repeat (2) step();
      req = 1'b0;
      step();
      req = 1'b1;
      wait_ack();
      step();
      req = 1'b0;
      repeat (GAP + 2) step();

      code = 8'hC3; req = 1'b1;
      wait_load();
      do_reset(2);
      wait_ack();
      step();
      req = 1'b0;
      repeat (GAP + 2) step();

      scramble = 1'b1;
      for (int i = 0; i < 30; i++) begin
        repeat ($urandom_range(0, 3)) step();
        req = 1'b1;
        pick = $urandom_range(0, 9);
        if (pick < 2) begin
          repeat ($urandom_range(1, W)) step();
          req = 1'b0;
          step();
        end else if (pick == 2) begin
          repeat ($urandom_range(1, W)) step();
          do_reset($urandom_range(1, 2));
          wait_ack();
          req = 1'b0;
          step();
        end else begin
          wait_ack();
          repeat ($urandom_range(0, 3)) step();
          req = 1'b0;
          step();
        end
      end
      scramble = 1'b0;
      req = 1'b0;
      repeat (W + GAP + 8) step();
    endtask

    initial begin
      rst = 1'b1; req = 1'b1; code = 8'hA5;
      repeat (3) step();
      req = 1'b0;
      step();
      rst = 1'b0;
      repeat (2) step();
      apply_stimulus();
      done = 1'b1;
    end
  end

  initial begin
    int t = 0;
    while (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done) && t < 50000) begin
      @(posedge clk);
      t++;
    end
    check_output("all_drivers_done",
                 32'({g_cfg[0].done, g_cfg[1].done, g_cfg[2].done}), 32'd7);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
